// File: rtl/delay_pkg.sv
// Shared helpers for the delay, window and line-buffer blocks: width math and
// delay-request clamping.
package delay_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'(1) << width) < 64'(value))
            width++;
        return width;
    endfunction

    // Width needed to express every delay 0..max_delay
    function automatic int unsigned dly_width(input int unsigned max_delay);
        return clog2(max_delay + 1);
    endfunction

    function automatic int unsigned clamp_dly(input int unsigned dly,
                                              input int unsigned max_delay);
        if (dly == 0)
            return 1;
        else if (dly > max_delay)
            return max_delay;
        return dly;
    endfunction

    function automatic logic dly_illegal(input int unsigned dly,
                                         input int unsigned max_delay);
        return (dly == 0) || (dly > max_delay);
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular sample store: one synchronous write port, one asynchronous read port.
module delay_ram #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 25,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale entries are masked by fill/primed upstream.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with a run-time selectable delay of 1..MAX_DELAY enabled
// cycles; equivalent to a chain of d enabled D flip-flops.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned CHANNELS   = 3,
    parameter  int unsigned MAX_DELAY  = 64,
    localparam int unsigned DLY_W      = dly_width(MAX_DELAY)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           E,
    input  logic                           CLR,
    input  logic [DLY_W-1:0]               DLY,
    input  logic                           IN_VALID,
    input  logic [CHANNELS*DATA_WIDTH-1:0] IN,
    output logic                           OUT_VALID,
    output logic [CHANNELS*DATA_WIDTH-1:0] out,
    output logic                           ERR_DLY
);

    localparam int unsigned     DW    = CHANNELS * DATA_WIDTH;
    localparam int unsigned     PTR_W = DLY_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(MAX_DELAY);

    logic [DLY_W-1:0] wr_ptr, fill, d;
    logic [DLY_W-1:0] rd_ptr, wr_ptr_next, fill_next;
    logic [PTR_W-1:0] rd_sum, wr_inc;
    logic             dly_bad, primed_next, primed_q, valid_q;
    logic [DW:0]      wr_word, rd_word, sample;

    delay_ram #(
        .DEPTH  (MAX_DELAY),
        .WIDTH  (DW + 1),
        .ADDR_W (DLY_W)
    ) u_ram (
        .clk     (CLK),
        .we      (E & ~CLR),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        d       = DLY_W'(clamp_dly(32'(DLY), MAX_DELAY));
        dly_bad = dly_illegal(32'(DLY), MAX_DELAY);
        wr_word = {IN_VALID, IN};

        // wr_ptr-(d-1) mod MAX_DELAY; adding DEPTH first keeps the sum non-negative
        rd_sum  = {1'b0, wr_ptr} + DEPTH - ({1'b0, d} - PTR_W'(1));
        rd_ptr  = DLY_W'((rd_sum >= DEPTH) ? rd_sum - DEPTH : rd_sum);

        wr_inc      = {1'b0, wr_ptr} + PTR_W'(1);
        wr_ptr_next = (wr_inc == DEPTH) ? '0 : wr_inc[DLY_W-1:0];
        fill_next   = ({1'b0, fill} == DEPTH) ? fill : fill + DLY_W'(1);
        primed_next = ({1'b0, fill} + PTR_W'(1)) >= {1'b0, d};

        sample = (d == DLY_W'(1)) ? wr_word : rd_word;
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            fill     <= '0;
            out      <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            ERR_DLY  <= 1'b0;
        end else if (CLR) begin
            wr_ptr   <= '0;
            fill     <= '0;
            out      <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            ERR_DLY  <= 1'b0;
        end else if (E) begin
            wr_ptr   <= wr_ptr_next;
            fill     <= fill_next;
            out      <= sample[DW-1:0];
            valid_q  <= sample[DW];
            primed_q <= primed_next;
            ERR_DLY  <= ERR_DLY | dly_bad;
        end
    end

    assign OUT_VALID = valid_q & primed_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: MAX_DELAY=64 and MAX_DELAY=10 instances share
// the stimulus and are each checked against a history-based reference model.
module tb_prog_delay_line;

    typedef struct {
        logic [23:0] data;
        logic        vld;
        logic        err;
        logic        known;
    } exp_t;

    logic        CLK, RST, E, CLR, in_valid;
    logic [6:0]  dly64;
    logic [3:0]  dly10;
    logic [23:0] in_data, out64, out10;
    logic        ov64, ov10, err64, err10;

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    exp_t q64[$];
    exp_t q10[$];

    logic [24:0] hbuf [2][0:1023];
    int          cnt     [2];
    logic [23:0] m_out   [2];
    logic        m_vld   [2];
    logic        m_err   [2];
    logic        m_known [2];

    prog_delay_line #(.DATA_WIDTH(8), .CHANNELS(3), .MAX_DELAY(64)) dut64 (
        .CLK(CLK), .RST(RST), .E(E), .CLR(CLR), .DLY(dly64), .IN_VALID(in_valid),
        .IN(in_data), .OUT_VALID(ov64), .out(out64), .ERR_DLY(err64)
    );

    prog_delay_line #(.DATA_WIDTH(8), .CHANNELS(3), .MAX_DELAY(10)) dut10 (
        .CLK(CLK), .RST(RST), .E(E), .CLR(CLR), .DLY(dly10), .IN_VALID(in_valid),
        .IN(in_data), .OUT_VALID(ov10), .out(out10), .ERR_DLY(err10)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        cnt[i]     = 0;
        m_out[i]   = '0;
        m_vld[i]   = 1'b0;
        m_err[i]   = 1'b0;
        m_known[i] = 1'b1;
    endtask

    // Reference: after enabled edge k, out = sample from enabled edge k-d+1 when k >= d
    task automatic model(input int i, input int maxd, input logic e, input logic clr,
                         input int dly, input logic iv, input logic [23:0] dat,
                         output exp_t x);
        int d;
        if (clr) begin
            model_reset(i);
        end else if (e) begin
            d = (dly == 0) ? 1 : (dly > maxd) ? maxd : dly;
            if (dly == 0 || dly > maxd)
                m_err[i] = 1'b1;
            hbuf[i][cnt[i]] = {iv, dat};
            cnt[i]++;
            if (cnt[i] >= d) begin
                m_out[i]   = hbuf[i][cnt[i]-d][23:0];
                m_vld[i]   = hbuf[i][cnt[i]-d][24];
                m_known[i] = 1'b1;
            end else begin
                m_vld[i]   = 1'b0;
                m_known[i] = 1'b0;
            end
        end
        x.data  = m_out[i];
        x.vld   = m_vld[i];
        x.err   = m_err[i];
        x.known = m_known[i];
    endtask

    task automatic compare(input string name, input logic ov, input logic [23:0] o,
                           input logic er, input exp_t x);
        check({name, " out_valid"}, 32'(ov), 32'(x.vld));
        check({name, " err_dly"}, 32'(er), 32'(x.err));
        if (x.known)
            check({name, " out"}, 32'(o), 32'(x.data));
    endtask

    task automatic step(input logic e, input logic clr, input int dly, input logic iv,
                        input logic [23:0] dat);
        exp_t x;
        step_no++;
        E        = e;
        CLR      = clr;
        dly64    = 7'(dly);
        dly10    = (dly > 15) ? 4'd15 : 4'(dly);
        in_valid = iv;
        in_data  = dat;
        model(0, 64, e, clr, dly, iv, dat, x);
        q64.push_back(x);
        model(1, 10, e, clr, int'(dly10), iv, dat, x);
        q10.push_back(x);
        @(posedge CLK);
        #1;
        x = q64.pop_front();
        compare("d64", ov64, out64, err64, x);
        x = q10.pop_front();
        compare("d10", ov10, out10, err10, x);
    endtask

    function automatic logic [23:0] pat(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b ^ 8'hA5, b + 8'd100, b};
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, " d64 out"}, 32'(out64), 32'h0);
        check({tag, " d64 out_valid"}, 32'(ov64), 32'h0);
        check({tag, " d64 err_dly"}, 32'(err64), 32'h0);
        check({tag, " d10 out"}, 32'(out10), 32'h0);
        check({tag, " d10 out_valid"}, 32'(ov10), 32'h0);
        check({tag, " d10 err_dly"}, 32'(err10), 32'h0);
    endtask

    initial begin
        RST = 1'b1; E = 1'b0; CLR = 1'b0; dly64 = '0; dly10 = '0;
        in_valid = 1'b0; in_data = '0;
        model_reset(0);
        model_reset(1);
        #12;
        check_zero_outputs("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Delay 12: first sample appears on the 12th edge; long run wraps both buffers
        for (int v = 1; v <= 80; v++)
            step(1'b1, 1'b0, 12, 1'b1, pat(v));

        // Delay 1 with some invalid samples travelling alongside the data
        step(1'b1, 1'b1, 1, 1'b0, '0);
        for (int v = 1; v <= 12; v++)
            step(1'b1, 1'b0, 1, (v % 4) != 0, pat(v + 40));

        // Delay 5 then 8 without flush; then flush and restart at 8
        step(1'b1, 1'b1, 5, 1'b0, '0);
        for (int v = 1; v <= 20; v++)
            step(1'b1, 1'b0, 5, 1'b1, pat(v));
        for (int v = 21; v <= 30; v++)
            step(1'b1, 1'b0, 8, 1'b1, pat(v));
        step(1'b0, 1'b1, 8, 1'b0, '0);
        for (int v = 1; v <= 10; v++)
            step(1'b1, 1'b0, 8, 1'b1, pat(v + 90));

        // Random enable with delay 4
        step(1'b1, 1'b1, 4, 1'b0, '0);
        for (int n = 0; n < 60; n++)
            step(1'($urandom_range(0, 1)), 1'b0, 4, 1'($urandom_range(0, 1)), 24'($urandom));

        // Illegal delays: 0 behaves as 1, MAX_DELAY+5 as MAX_DELAY; error is sticky
        step(1'b1, 1'b1, 1, 1'b0, '0);
        for (int v = 1; v <= 4; v++)
            step(1'b1, 1'b0, 0, 1'b1, pat(v));
        for (int v = 5; v <= 75; v++)
            step(1'b1, 1'b0, 69, 1'b1, pat(v));
        for (int v = 76; v <= 80; v++)
            step(1'b1, 1'b0, 3, 1'b1, pat(v));
        step(1'b0, 1'b0, 3, 1'b1, pat(81));
        step(1'b0, 1'b1, 3, 1'b1, pat(82));
        step(1'b1, 1'b0, 3, 1'b1, pat(83));

        // Asynchronous reset between edges
        for (int v = 1; v <= 15; v++)
            step(1'b1, 1'b0, 6, 1'b1, pat(v + 150));
        #3;
        RST = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        model_reset(0);
        model_reset(1);
        #2;
        RST = 1'b0;
        for (int v = 1; v <= 10; v++)
            step(1'b1, 1'b0, 6, 1'b1, pat(v + 200));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
